mem_access: RTL and testbench
=============================

# mem_access

Memory-access (MEM) stage logic of the five-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It turns the MEM-stage load/store fields into transactions on the SRAM-like data bus (req/addr_ok/data_ok). It aligns and extends load data, replicates store data, and flags misaligned accesses. It requests a pipeline stall while a transaction is outstanding, and drains orphaned transactions after a flush.

## Interface
Parameters: none.
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- stallM  in  1  global MEM-stage stall from hazard unit (includes this block's stall_reqM)
- flushM  in  1  kill the instruction currently in MEM
- alu_outM  in  32  effective address / ALU result
- mem_readM, mem_writeM  in  1 each  load / store (never both)
- mem_sizeM  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word)
- mem_signM  in  1  sign-extend loads
- write_dataM  in  32  store source register value
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  as mem_sizeM
- data_addr  out  32  byte address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  transaction complete / read data valid
- data_rdata  in  32  read word
- resultM  out  32  value forwarded to MEM/WB: extended load data for loads, else alu_outM
- addr_errM  out  1  misaligned access (half with addr[0]=1, word with addr[1:0]≠0)
- stall_reqM  out  1  MEM needs to hold the pipeline

## Operation
- mem_op = (mem_readM | mem_writeM) & ~addr_errM. A misaligned access issues no request, does not stall, and drives resultM = alu_outM.
- Store data: byte → {4{wd[7:0]}}, half → {2{wd[15:0]}}, word → wd.
- Load data: the byte is rdata lane addr[1:0]; the half is lane addr[1]. Extension uses mem_signM.
- States:
  - IDLE:
    - data_req = mem_op & ~flushM. data_addr/wr/size/wdata come directly from the inputs and are also latched.
    - If data_addr_ok: go to WAIT. Else if request raised: go to REQ.
  - REQ:
    - data_req = 1, driving the latched fields.
    - flushM sets the drop flag. The request is never withdrawn before data_addr_ok.
    - On data_addr_ok: go to DRAIN if drop is set (including a flush this cycle), else go to WAIT.
  - WAIT:
    - On data_data_ok: latch the processed load data and go to DONE.
    - flushM: go to IDLE if data_data_ok in the same cycle, else go to DRAIN.
  - DONE:
    - resultM comes from the latched data.
    - flushM, or ~stallM (the stage advances): go to IDLE.
  - DRAIN:
    - data_req = 0; on data_data_ok discard the data and go to IDLE.
- stall_reqM = mem_op & (state ≠ DONE). It does not depend on stallM, so there is no combinational loop.
- A new instruction that arrives during DRAIN with a memory op therefore stalls until IDLE and then issues.
- resultM for loads uses the DONE latch. For stores and non-memory ops it is alu_outM.

## Timing
- Reset (rst=1 at a clk edge): state=IDLE, drop=0, load latch=0.
- While rst is high, data_req=0 and stall_reqM=0. resultM and addr_errM remain combinational.
- Fastest access: addr_ok in the IDLE cycle (cycle 0), data_ok in cycle 1, DONE in cycle 2. stall_reqM is high in cycles 0–1; the instruction leaves MEM at the end of cycle 2.
- The bus never returns data_ok in the same cycle as the matching addr_ok. At most one transaction is outstanding.
- data_addr/wdata/size/wr are held stable from the first data_req cycle until addr_ok.
- If stallM is held in DONE (another stage stalling), no re-issue occurs and resultM stays stable.
- Simultaneous flushM and data_data_ok in WAIT: the data is dropped and the next state is IDLE.
- rst mid-transaction: the FSM returns to IDLE. The bus is reset by the same rst.

## Test plan
- LW at 0x100, addr_ok in cycle 0, data_ok in cycle 3 with rdata=0x8899AABB → stall_reqM high for cycles 0–3, resultM=0x8899AABB in cycle 4, stall_reqM=0.
- LB signed at 0x103 with rdata=0x80FF1234 → resultM=0xFFFFFF80. LHU at 0x102 with the same rdata → 0x000080FF.
- SB of wd=0x000000A5 at 0x201 → data_wr=1, data_size=0, data_wdata=0xA5A5A5A5. resultM=alu_outM after data_ok.
- LH at 0x101 → addr_errM=1, data_req=0, stall_reqM=0. SW at 0x102 → addr_errM=1.
- LW with addr_ok delayed 2 cycles, flushM in cycle 1 → req held until addr_ok, then DRAIN. A following LW is stalled until data_ok of the dropped access, then issues normally.
- Load completes (DONE) while stallM is held for 3 cycles → exactly one bus request, resultM constant, IDLE after stallM drops.

Source files
------------

// File: rtl/mem_access.sv
// MEM-stage bus adapter: drives the SRAM-like data bus for loads and stores,
// aligns/extends load data, and stalls or drains around outstanding transactions.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM,
  input  logic        flushM,
  input  logic [31:0] alu_outM,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_signM,
  input  logic [31:0] write_dataM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] resultM,
  output logic        addr_errM,
  output logic        stall_reqM
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t      state, state_n;
  logic        drop, drop_n;
  logic [31:0] lat_addr, lat_wdata, ld_data, ld_fmt, wdata_rep;
  logic [1:0]  lat_size;
  logic        lat_wr, lat_sign;
  logic        capture, ld_cap;
  logic        is_mem, misalign, mem_op;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem    = mem_readM | mem_writeM;
  assign misalign  = (mem_sizeM == 2'd0) ? 1'b0 :
                     (mem_sizeM == 2'd1) ? alu_outM[0] : (alu_outM[1:0] != 2'b00);
  assign addr_errM = is_mem & misalign;
  assign mem_op    = is_mem & ~addr_errM;

  always_comb begin
    wdata_rep = write_dataM;
    case (mem_sizeM)
      2'd0:    wdata_rep = {4{write_dataM[7:0]}};
      2'd1:    wdata_rep = {2{write_dataM[15:0]}};
      default: wdata_rep = write_dataM;
    endcase
  end

  // Load extraction uses the fields latched at issue, not the live inputs.
  always_comb begin
    ld_byte = 8'h00;
    case (lat_addr[1:0])
      2'd0: ld_byte = data_rdata[7:0];
      2'd1: ld_byte = data_rdata[15:8];
      2'd2: ld_byte = data_rdata[23:16];
      2'd3: ld_byte = data_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = lat_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (lat_size)
      2'd0:    ld_fmt = {{24{lat_sign & ld_byte[7]}}, ld_byte};
      2'd1:    ld_fmt = {{16{lat_sign & ld_half[15]}}, ld_half};
      default: ld_fmt = data_rdata;
    endcase
  end

  always_comb begin
    state_n    = state;
    drop_n     = drop;
    capture    = 1'b0;
    ld_cap     = 1'b0;
    data_req   = 1'b0;
    data_addr  = lat_addr;
    data_wr    = lat_wr;
    data_size  = lat_size;
    data_wdata = lat_wdata;
    case (state)
      S_IDLE: begin
        data_addr  = alu_outM;
        data_wr    = mem_writeM;
        data_size  = mem_sizeM;
        data_wdata = wdata_rep;
        data_req   = mem_op & ~flushM & ~rst;
        capture    = 1'b1;
        drop_n     = 1'b0;
        if (data_req) state_n = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        data_req = ~rst;
        if (flushM) drop_n = 1'b1;
        if (data_addr_ok) begin
          state_n = (drop | flushM) ? S_DRAIN : S_WAIT;
          drop_n  = 1'b0;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_n = flushM ? S_IDLE : S_DONE;
          ld_cap  = ~flushM;
        end else if (flushM) begin
          state_n = S_DRAIN;
        end
      end
      S_DONE:  if (flushM | ~stallM) state_n = S_IDLE;
      S_DRAIN: if (data_data_ok) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drop      <= 1'b0;
      ld_data   <= 32'h0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_size  <= 2'd0;
      lat_wr    <= 1'b0;
      lat_sign  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
      if (capture) begin
        lat_addr  <= alu_outM;
        lat_wdata <= wdata_rep;
        lat_size  <= mem_sizeM;
        lat_wr    <= mem_writeM;
        lat_sign  <= mem_signM;
      end
      if (ld_cap) ld_data <= ld_fmt;
    end
  end

  assign resultM    = (mem_readM & mem_op) ? ld_data : alu_outM;
  assign stall_reqM = mem_op & (state != S_DONE) & ~rst;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: drives the bus handshake by hand and scoreboards load results.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst, stallM, flushM, mem_readM, mem_writeM, mem_signM;
  logic [31:0] alu_outM, write_dataM, data_addr, data_wdata, data_rdata, resultM;
  logic [1:0]  mem_sizeM, data_size;
  logic        data_req, data_wr, data_addr_ok, data_data_ok, addr_errM, stall_reqM;

  int vectors = 0;
  int fails   = 0;
  int hs      = 0;
  int hs_base;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  mem_access dut (
    .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM), .alu_outM(alu_outM),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_sizeM(mem_sizeM),
    .mem_signM(mem_signM), .write_dataM(write_dataM), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .resultM(resultM), .addr_errM(addr_errM),
    .stall_reqM(stall_reqM)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && data_req && data_addr_ok) hs <= hs + 1;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] addr, input logic [31:0] wd);
    mem_readM = rd; mem_writeM = wr; mem_sizeM = sz; mem_signM = sg;
    alu_outM = addr; write_dataM = wd;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
  endtask

  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) begin
      vectors++; fails++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, resultM);
    end else begin
      chk(tag, resultM, exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1; stallM = 0; flushM = 0;
    op(1, 0, 2'd2, 0, 32'h100, 32'h0);
    bus(0, 0, 32'h0);
    tick(); settle();
    chk("rst_req",   {31'b0, data_req},   32'd0);
    chk("rst_stall", {31'b0, stall_reqM}, 32'd0);
    chk("rst_ldlat", resultM,             32'h0);
    tick();
    rst = 0;
    op(0, 0, 2'd0, 0, 32'h1234, 32'h0);
    settle();
    chk("nop_result", resultM, 32'h1234);
    chk("nop_req", {31'b0, data_req}, 32'd0);

    // LW 0x100, addr_ok cycle 0, data_ok cycle 3
    tick();
    op(1, 0, 2'd2, 0, 32'h100, 32'h0); stallM = 1; bus(1, 0, 32'h0);
    exp_q.push_back(32'h8899AABB);
    settle();
    chk("lw_req",   {31'b0, data_req},   32'd1);
    chk("lw_addr",  data_addr,           32'h100);
    chk("lw_wr",    {31'b0, data_wr},    32'd0);
    chk("lw_st0",   {31'b0, stall_reqM}, 32'd1);
    tick(); bus(0, 0, 32'h0); settle();
    chk("lw_st1",   {31'b0, stall_reqM}, 32'd1);
    chk("lw_noreq", {31'b0, data_req},   32'd0);
    tick(); settle();
    chk("lw_st2",   {31'b0, stall_reqM}, 32'd1);
    tick(); bus(0, 1, 32'h8899AABB); settle();
    chk("lw_st3",   {31'b0, stall_reqM}, 32'd1);
    tick(); bus(0, 0, 32'h0); stallM = 0; settle();
    chk("lw_st4",   {31'b0, stall_reqM}, 32'd0);
    sb_check("lw_result");

    // LB signed at 0x103
    tick();
    op(1, 0, 2'd0, 1, 32'h103, 32'h0); stallM = 1; bus(1, 0, 32'h0);
    exp_q.push_back(32'hFFFFFF80);
    settle();
    chk("lb_size", {30'b0, data_size}, 32'd0);
    chk("lb_addr", data_addr,          32'h103);
    tick(); bus(0, 1, 32'h80FF1234);
    tick(); bus(0, 0, 32'h0); stallM = 0; settle();
    sb_check("lb_result");

    // LHU at 0x102
    tick();
    op(1, 0, 2'd1, 0, 32'h102, 32'h0); stallM = 1; bus(1, 0, 32'h0);
    exp_q.push_back(32'h000080FF);
    tick(); bus(0, 1, 32'h80FF1234);
    tick(); bus(0, 0, 32'h0); stallM = 0; settle();
    chk("lhu_stall", {31'b0, stall_reqM}, 32'd0);
    sb_check("lhu_result");

    // SB 0xA5 at 0x201
    tick();
    op(0, 1, 2'd0, 0, 32'h201, 32'h000000A5); stallM = 1; bus(1, 0, 32'h0);
    settle();
    chk("sb_wr",    {31'b0, data_wr},   32'd1);
    chk("sb_size",  {30'b0, data_size}, 32'd0);
    chk("sb_wdata", data_wdata,         32'hA5A5A5A5);
    tick(); bus(0, 1, 32'h0);
    tick(); bus(0, 0, 32'h0); stallM = 0; settle();
    chk("sb_result", resultM, 32'h201);
    chk("sb_stall",  {31'b0, stall_reqM}, 32'd0);

    // misaligned accesses
    tick();
    op(1, 0, 2'd1, 1, 32'h101, 32'h0); bus(1, 0, 32'h0); settle();
    chk("lh_err",    {31'b0, addr_errM},  32'd1);
    chk("lh_req",    {31'b0, data_req},   32'd0);
    chk("lh_stall",  {31'b0, stall_reqM}, 32'd0);
    chk("lh_result", resultM,             32'h101);
    op(0, 1, 2'd2, 0, 32'h102, 32'h0); settle();
    chk("sw_err",    {31'b0, addr_errM},  32'd1);
    op(0, 1, 2'd1, 0, 32'h102, 32'h0); settle();
    chk("sh_ok",     {31'b0, addr_errM},  32'd0);
    op(0, 0, 2'd0, 0, 32'h0, 32'h0); bus(0, 0, 32'h0); settle();

    // LW 0x300 with delayed addr_ok and flush in cycle 1
    tick();
    op(1, 0, 2'd2, 0, 32'h300, 32'h0); stallM = 1; settle();
    chk("fl_req0", {31'b0, data_req}, 32'd1);
    tick(); flushM = 1; alu_outM = 32'h304; settle();
    chk("fl_req1",  {31'b0, data_req}, 32'd1);
    chk("fl_hold1", data_addr,         32'h300);
    tick(); flushM = 0; op(1, 0, 2'd2, 0, 32'h400, 32'h0); bus(1, 0, 32'h0); settle();
    chk("fl_req2",  {31'b0, data_req}, 32'd1);
    chk("fl_hold2", data_addr,         32'h300);
    tick(); bus(0, 0, 32'h0); settle();
    chk("dr_req",   {31'b0, data_req},   32'd0);
    chk("dr_stall", {31'b0, stall_reqM}, 32'd1);
    tick(); bus(0, 1, 32'hDEADBEEF); settle();
    chk("dr_req2",  {31'b0, data_req},   32'd0);
    chk("dr_stall2",{31'b0, stall_reqM}, 32'd1);
    tick(); bus(1, 0, 32'h0); exp_q.push_back(32'h12345678); settle();
    chk("nx_req",  {31'b0, data_req}, 32'd1);
    chk("nx_addr", data_addr,         32'h400);
    tick(); bus(0, 1, 32'h12345678);
    tick(); bus(0, 0, 32'h0); stallM = 0; settle();
    sb_check("nx_result");

    // DONE held by external stall for three cycles
    tick();
    op(1, 0, 2'd2, 0, 32'h500, 32'h0); stallM = 1; bus(1, 0, 32'h0);
    exp_q.push_back(32'hCAFEF00D);
    hs_base = hs;
    tick(); bus(0, 1, 32'hCAFEF00D);
    tick(); bus(1, 0, 32'h0); settle();
    sb_check("hold_result");
    held = resultM;
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      chk("hold_stable", resultM, 32'hCAFEF00D);
      chk("hold_noreq",  {31'b0, data_req}, 32'd0);
    end
    stallM = 0;
    tick(); bus(0, 0, 32'h0); op(1, 0, 2'd2, 0, 32'h600, 32'h0); stallM = 1; settle();
    chk("hold_hs", hs - hs_base, 32'd1);
    chk("idle_req", {31'b0, data_req}, 32'd1);

    // reset while a request is pending
    tick(); rst = 1; settle();
    chk("mrst_req",   {31'b0, data_req},   32'd0);
    chk("mrst_stall", {31'b0, stall_reqM}, 32'd0);
    tick(); rst = 0; bus(1, 0, 32'h0); exp_q.push_back(32'h0BADF00D); settle();
    chk("post_req",  {31'b0, data_req}, 32'd1);
    chk("post_addr", data_addr,         32'h600);
    tick(); bus(0, 1, 32'h0BADF00D);
    tick(); bus(0, 0, 32'h0); stallM = 0; settle();
    sb_check("post_result");
    tick(); op(0, 0, 2'd0, 0, 32'h0, 32'h0); settle();
    chk("end_req", {31'b0, data_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
